axi_wr_arbiter_2x1: RTL and testbench
=====================================

Name: axi_wr_arbiter_2x1

Overview:
Two-master AXI4 write-path arbiter. It produces the select and enable controls for the 2:1 enabled muxes that steer AW, W and B channels onto one slave port.
- Grant is round-robin and locked for the whole transaction: AW handshake, then all W beats through WLAST, then the B handshake.
- It also counts W beats against AWLEN and flags any WLAST mismatch.
- Sits in the interconnect datapath between the master-side channel inputs and the mux select/enable lines.

Parameters:
LEN_W, 8, AWLEN width (AXI4 = 8)
CNT_W, 9, beat counter width; must be >= LEN_W+1

Ports:
ACLK  input  1  clock
ARESETN  input  1  asynchronous active-low reset
m0_awvalid  input  1  master 0 address request
m1_awvalid  input  1  master 1 address request
s_awready  input  1  slave AWREADY
s_awlen  input  LEN_W  AWLEN after the mux (granted master)
s_wvalid  input  1  WVALID after the mux
s_wready  input  1  slave WREADY
s_wlast  input  1  WLAST after the mux
s_bvalid  input  1  slave BVALID
s_bready  input  1  BREADY after the mux
mux_sel  output  1  mux select: 0 = master 0 (in1), 1 = master 1 (in2)
mux_en  output  1  mux enable; 0 forces mux outputs to zero
m0_grant  output  1  master 0 owns the slave port
m1_grant  output  1  master 1 owns the slave port
busy  output  1  transaction in progress (state != IDLE)
wlast_err  output  1  one-cycle pulse on a WLAST/beat-count mismatch

Behaviour:
- FSM states: IDLE, ADDR, DATA, RESP. All outputs are registered.
- Reset (ARESETN low, asynchronous): state=IDLE, mux_sel=0, mux_en=0, grants=0, busy=0, wlast_err=0, beat counter=0, rr pointer=0 (master 0 preferred next).
- Reset asserted mid-transaction aborts immediately; no completion is attempted.
- IDLE:
  - Any request present: grant the master chosen by the rr pointer if it is requesting, else the other one.
  - Both requesting: the rr pointer decides.
  - Next cycle: state=ADDR, mux_en=1, mux_sel=winner, the winner's grant=1.
  - Grant latency is 1 cycle from AWVALID in IDLE.
- ADDR: wait for a handshake (s_awready & granted awvalid). On the handshake, capture beats = s_awlen+1 into the counter and move to DATA.
- DATA: each s_wvalid & s_wready decrements the counter.
  - Error if a beat has s_wlast=1 while counter != 1, or counter == 1 while s_wlast=0. Either case pulses wlast_err for 1 cycle.
  - A beat with s_wlast=1 moves to RESP regardless of any mismatch.
- RESP: on s_bvalid & s_bready, move to IDLE.
  - Same edge: mux_en=0, grants=0, rr pointer = the other master.
- Simultaneous events:
  - A new request arriving during RESP completion is not granted before the IDLE cycle; minimum 1 idle cycle between transactions.
  - Requests arriving while the grant is locked are ignored until IDLE.
- Granted master dropping awvalid in ADDR (protocol violation): the grant is held.
- awlen=0: a single beat; WLAST on the first beat is correct.
- awlen=255: 256 beats; the counter must not wrap.
- Outputs mux_sel and grant change only on entering ADDR or leaving RESP.

Optional Feature:
AXI_ARB_WR_TIMEOUT_EN
- Defined: an extra 16-bit counter runs in ADDR/DATA/RESP and resets on every handshake.
  - At 0xFFFF: return to IDLE, drop mux_en and the grants, pulse output timeout_err (extra 1-bit port, reset 0), and flip the rr pointer.
- Undefined: no counter, no timeout_err port; the grant is held indefinitely.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2, RESP=2'd3)
  - master index constants M0=1'b0, M1=1'b1
  - timeout limit constant 16'hFFFF
- Natural sub-module: rr_arb_2 — combinational 2-requester round-robin picker taking a request vector and the pointer, returning the winner and a valid flag.
- The beat counter and FSM stay in the top block.

Test Plan:
- Only m0_awvalid=1, awlen=3, 4 beats with WLAST on beat 4, then B handshake -> mux_en=1 and sel=0 one cycle after the request; busy drops the cycle after B; wlast_err never pulses.
- m0 and m1 request together from reset -> m0 granted first (sel=0); after its B, m1 granted (sel=1) on the next IDLE; the third contention goes to m0.
- awlen=0 single beat with WLAST=1 -> no error, RESP entered the next cycle.
- awlen=2 with WLAST on beat 2 -> wlast_err pulses 1 cycle; FSM goes to RESP.
- ARESETN pulsed low in DATA with beat counter mid-burst -> outputs zero asynchronously; after release, IDLE with rr pointer=0.
- With AXI_ARB_WR_TIMEOUT_EN: grant m1, withhold s_wready for 65535 cycles -> timeout_err pulse, mux_en=0, next grant prefers m0.

Source files
------------

// File: rtl/axi_wr_arbiter_2x1_pkg.sv
// Shared types and constants for the two-master AXI4 write-path arbiter.
package axi_wr_arbiter_2x1_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StResp = 2'd3
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [15:0] TimeoutLimit = 16'hFFFF;

endpackage

// File: rtl/axi_wr_arbiter_2x1_rr_arb_2.sv
// Combinational two-requester round-robin picker: the pointed-to requester wins if it asks,
// otherwise the other one.
module axi_wr_arbiter_2x1_rr_arb_2
    import axi_wr_arbiter_2x1_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = req[ptr] ? ptr : ~ptr;
    end

endmodule

// File: rtl/axi_wr_arbiter_2x1.sv
// Two-master AXI4 write arbiter: round-robin grant locked from AW through B, plus WLAST checking.
// Optional build macro AXI_ARB_WR_TIMEOUT_EN adds a 16-bit watchdog and the timeout_err port.
module axi_wr_arbiter_2x1
    import axi_wr_arbiter_2x1_pkg::*;
#(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned CNT_W = 9
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             m0_awvalid,
    input  logic             m1_awvalid,
    input  logic             s_awready,
    input  logic [LEN_W-1:0] s_awlen,
    input  logic             s_wvalid,
    input  logic             s_wready,
    input  logic             s_wlast,
    input  logic             s_bvalid,
    input  logic             s_bready,
    output logic             mux_sel,
    output logic             mux_en,
    output logic             m0_grant,
    output logic             m1_grant,
    output logic             busy,
`ifdef AXI_ARB_WR_TIMEOUT_EN
    output logic             timeout_err,
`endif
    output logic             wlast_err
);

    arb_state_e       state;
    logic [CNT_W-1:0] beat_cnt;
    logic             rr_ptr;
    logic             arb_winner;
    logic             arb_valid;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;
    logic             cnt_is_one;
    logic [CNT_W-1:0] beats_init;

    axi_wr_arbiter_2x1_rr_arb_2 u_rr_arb (
        .req    ({m1_awvalid, m0_awvalid}),
        .ptr    (rr_ptr),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    always_comb begin
        aw_hs      = s_awready & (mux_sel ? m1_awvalid : m0_awvalid);
        w_hs       = s_wvalid & s_wready;
        b_hs       = s_bvalid & s_bready;
        cnt_is_one = (beat_cnt == CNT_W'(1));
        // Counter is one bit wider than AWLEN so 255+1 does not wrap.
        beats_init = CNT_W'(s_awlen) + CNT_W'(1);
    end

`ifdef AXI_ARB_WR_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        any_hs;

    always_comb begin
        any_hs = ((state == StAddr) & aw_hs) | ((state == StData) & w_hs) |
                 ((state == StResp) & b_hs);
    end
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= StIdle;
            beat_cnt  <= '0;
            rr_ptr    <= M0;
            mux_sel   <= M0;
            mux_en    <= 1'b0;
            m0_grant  <= 1'b0;
            m1_grant  <= 1'b0;
            busy      <= 1'b0;
            wlast_err <= 1'b0;
`ifdef AXI_ARB_WR_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            wlast_err <= 1'b0;
            case (state)
                StIdle: begin
                    if (arb_valid) begin
                        state    <= StAddr;
                        mux_en   <= 1'b1;
                        mux_sel  <= arb_winner;
                        m0_grant <= (arb_winner == M0);
                        m1_grant <= (arb_winner == M1);
                        busy     <= 1'b1;
                    end
                end
                StAddr: begin
                    if (aw_hs) begin
                        beat_cnt <= beats_init;
                        state    <= StData;
                    end
                end
                StData: begin
                    if (w_hs) begin
                        if (beat_cnt != '0) begin
                            beat_cnt <= beat_cnt - CNT_W'(1);
                        end
                        wlast_err <= s_wlast ? ~cnt_is_one : cnt_is_one;
                        if (s_wlast) begin
                            state <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (b_hs) begin
                        state    <= StIdle;
                        mux_en   <= 1'b0;
                        m0_grant <= 1'b0;
                        m1_grant <= 1'b0;
                        busy     <= 1'b0;
                        rr_ptr   <= ~mux_sel;
                    end
                end
                default: state <= StIdle;
            endcase
`ifdef AXI_ARB_WR_TIMEOUT_EN
            timeout_err <= 1'b0;
            // Watchdog expiry overrides whatever the FSM decided this cycle.
            if (state == StIdle) begin
                to_cnt <= '0;
            end else if (to_cnt == TimeoutLimit) begin
                state       <= StIdle;
                mux_en      <= 1'b0;
                m0_grant    <= 1'b0;
                m1_grant    <= 1'b0;
                busy        <= 1'b0;
                rr_ptr      <= ~mux_sel;
                timeout_err <= 1'b1;
                to_cnt      <= '0;
            end else if (any_hs) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter_2x1.sv
// Directed self-checking bench for the two-master AXI4 write arbiter.
module tb_axi_wr_arbiter_2x1;

    logic       ACLK = 1'b0;
    logic       ARESETN;
    logic       m0_awvalid, m1_awvalid, s_awready;
    logic [7:0] s_awlen;
    logic       s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic       mux_sel, mux_en, m0_grant, m1_grant, busy, wlast_err;
`ifdef AXI_ARB_WR_TIMEOUT_EN
    logic       timeout_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 ACLK = ~ACLK;

    axi_wr_arbiter_2x1 #(
        .LEN_W (8),
        .CNT_W (9)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .m0_awvalid (m0_awvalid),
        .m1_awvalid (m1_awvalid),
        .s_awready  (s_awready),
        .s_awlen    (s_awlen),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .s_wlast    (s_wlast),
        .s_bvalid   (s_bvalid),
        .s_bready   (s_bready),
        .mux_sel    (mux_sel),
        .mux_en     (mux_en),
        .m0_grant   (m0_grant),
        .m1_grant   (m1_grant),
        .busy       (busy),
`ifdef AXI_ARB_WR_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .wlast_err  (wlast_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_en"}, mux_en, 0);
        check_eq({tag, "_g0"}, m0_grant, 0);
        check_eq({tag, "_g1"}, m1_grant, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_werr"}, wlast_err, 0);
    endtask

    task automatic check_owner(input string tag, input logic sel);
        check_eq({tag, "_en"}, mux_en, 1);
        check_eq({tag, "_sel"}, mux_sel, sel);
        check_eq({tag, "_g0"}, m0_grant, !sel);
        check_eq({tag, "_g1"}, m1_grant, sel);
        check_eq({tag, "_busy"}, busy, 1);
    endtask

    // Requests must already be driven while the arbiter is idle.
    task automatic run_txn(input logic exp_sel, input logic [7:0] awlen, input int last_beat,
                           input string tag);
        int cnt;
        step();
        check_owner({tag, "_grant"}, exp_sel);
        s_awready = 1'b1;
        s_awlen   = awlen;
        step();
        s_awready = 1'b0;
        if (exp_sel) m1_awvalid = 1'b0;
        else m0_awvalid = 1'b0;
        cnt = int'(awlen) + 1;
        for (int b = 1; b <= last_beat; b++) begin
            s_wvalid = 1'b1;
            s_wready = 1'b1;
            s_wlast  = (b == last_beat);
            step();
            check_eq({tag, "_werr"}, wlast_err, (b == last_beat) ? (cnt != 1) : (cnt == 1));
            cnt--;
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        step();
        check_eq({tag, "_werr_gone"}, wlast_err, 0);
        check_owner({tag, "_resp"}, exp_sel);
        s_bvalid = 1'b1;
        s_bready = 1'b1;
        step();
        s_bvalid = 1'b0;
        s_bready = 1'b0;
        check_idle({tag, "_done"});
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        step();
        step();
        ARESETN = 1'b1;
    endtask

    initial begin
        ARESETN    = 1'b0;
        m0_awvalid = 1'b0;
        m1_awvalid = 1'b0;
        s_awready  = 1'b0;
        s_awlen    = 8'd0;
        s_wvalid   = 1'b0;
        s_wready   = 1'b0;
        s_wlast    = 1'b0;
        s_bvalid   = 1'b0;
        s_bready   = 1'b0;
        #2;
        check_idle("rst");
        check_eq("rst_sel", mux_sel, 0);
        do_reset();
        step();
        check_idle("rst_idle");

        // Lone m0, awlen=3 with WLAST on beat 4; leaves rr pointing at m1.
        m0_awvalid = 1'b1;
        run_txn(1'b0, 8'd3, 4, "m0_len3");

        // Both request with rr=1: m1 wins; dropped awvalid in ADDR keeps grant.
        m0_awvalid = 1'b1;
        m1_awvalid = 1'b1;
        step();
        check_owner("abort_grant", 1'b1);
        m1_awvalid = 1'b0;
        step();
        check_owner("addr_hold", 1'b1);
        m1_awvalid = 1'b1;
        s_awready  = 1'b1;
        s_awlen    = 8'd7;
        step();
        s_awready = 1'b0;
        s_wvalid  = 1'b1;
        s_wready  = 1'b1;
        step();
        step();
        check_owner("abort_data", 1'b1);
        #2;
        ARESETN = 1'b0;
        #1;
        check_idle("abort_async");
        check_eq("abort_sel", mux_sel, 0);
        s_wvalid = 1'b0;
        s_wready = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        check_idle("abort_rel");
        // Pointer back at m0 even though m1 was preferred before reset.
        run_txn(1'b0, 8'd0, 1, "post_rst");

        // Contention sequence from a fresh reset: m0, m1, m0.
        m0_awvalid = 1'b0;
        m1_awvalid = 1'b0;
        do_reset();
        m0_awvalid = 1'b1;
        m1_awvalid = 1'b1;
        run_txn(1'b0, 8'd1, 2, "cont1");
        m0_awvalid = 1'b1;
        run_txn(1'b1, 8'd1, 2, "cont2");
        m1_awvalid = 1'b1;
        run_txn(1'b0, 8'd0, 1, "cont3");

        // awlen=2 with early WLAST on beat 2; m1 still requesting from cont3.
        run_txn(1'b1, 8'd2, 2, "early_last");

        // awlen=0 single beat, then the full 256-beat burst.
        m0_awvalid = 1'b1;
        run_txn(1'b0, 8'd0, 1, "single");
        m1_awvalid = 1'b1;
        run_txn(1'b1, 8'd255, 256, "len255");

`ifdef AXI_ARB_WR_TIMEOUT_EN
        begin
            bit seen = 1'b0;
            m1_awvalid = 1'b1;
            step();
            check_owner("to_grant", 1'b1);
            s_awready = 1'b1;
            step();
            s_awready  = 1'b0;
            m1_awvalid = 1'b0;
            s_wvalid   = 1'b1;
            for (int i = 0; i < 70000; i++) begin
                step();
                if (timeout_err) begin
                    seen = 1'b1;
                    break;
                end
            end
            s_wvalid = 1'b0;
            check_eq("to_pulse", seen, 1);
            check_idle("to_idle");
            m0_awvalid = 1'b1;
            m1_awvalid = 1'b1;
            run_txn(1'b0, 8'd0, 1, "to_next");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
